// File: rtl/fig_14_cache_pkg.sv
// Shared types and constants for the instruction-cache fill controller.
package fig_14_cache_pkg;

    localparam int ROWS       = 64;
    localparam int LINE_BYTES = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t HIT    = 3'd1;
    localparam state_t BYPASS = 3'd2;
    localparam state_t FILL   = 3'd3;
    localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/fig_14_cache_ram.sv
// Cache data array: one write port, one registered read port, no reset.
module fig_14_cache_ram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/fig_14_cache_fill_ctrl.sv
// I-cache fill/lookup controller: hit, row fill, or out-of-range bypass.
// Optional EARLY_RESTART_EN: acknowledge the fetch as soon as its byte arrives.
module fig_14_cache_fill_ctrl
    import fig_14_cache_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int LINE_W = $clog2(LINE_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              orange,
    input  logic [ROW_W-1:0]  cache_addr,
    input  logic              cache_flush,
    output logic              fetch_ack,
    output logic [7:0]        fetch_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data
);

    localparam int BASE_W = ADDR_W - LINE_W;
    localparam int RA_W   = ROW_W + LINE_W;
    localparam int NROWS  = 1 << ROW_W;

`ifdef EARLY_RESTART_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0]   off_q, off_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [7:0]          data_q, data_d;
    logic [NROWS-1:0]    valid_q, valid_d;
    logic                fseen_q, fseen_d;
    logic                ackd_q, ackd_d;
    logic                early_q, early_d;
    logic                ram_we;
    logic [7:0]          ram_rdata;

    assign ram_we = (state_q == FILL) && mem_ack;

    fig_14_cache_ram #(.AW(RA_W), .DW(8)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i ({row_q, cnt_q}),
        .wdata_i (mem_data),
        .raddr_i ({cache_addr, pc[LINE_W-1:0]}),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    if (orange)
                        state_d = BYPASS;
                    else if (cache_flush || !valid_q[cache_addr])
                        state_d = FILL;
                    else
                        state_d = HIT;
                end
            end
            HIT:    state_d = IDLE;
            BYPASS: if (mem_ack) state_d = DONE;
            FILL:   if (mem_ack && cnt_q == '1) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_ack  = early_q;
        fetch_data = data_q;
        mem_req    = 1'b0;
        mem_addr   = '0;
        unique case (state_q)
            HIT: begin
                fetch_ack  = 1'b1;
                fetch_data = ram_rdata;
            end
            BYPASS: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {base_q, cnt_q};
            end
            DONE:    if (ackd_q) fetch_ack = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        off_d   = off_q;
        row_d   = row_q;
        base_d  = base_q;
        data_d  = data_q;
        valid_d = valid_q;
        fseen_d = fseen_q;
        ackd_d  = ackd_q;
        early_d = 1'b0;
        if (state_q == IDLE && state_d == FILL) begin
            row_d   = cache_addr;
            base_d  = pc[ADDR_W-1:LINE_W];
            off_d   = pc[LINE_W-1:0];
            cnt_d   = '0;
            fseen_d = 1'b0;
            ackd_d  = !EARLY;
        end
        if (state_q == IDLE && state_d == BYPASS)
            ackd_d = 1'b1;
        if (state_q == BYPASS && mem_ack)
            data_d = mem_data;
        if (state_q == FILL) begin
            if (mem_ack) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == off_q) begin
                    data_d  = mem_data;
                    early_d = EARLY;
                end
                if (cnt_q == '1 && !fseen_q)
                    valid_d[row_q] = 1'b1;
            end
            if (cache_flush) fseen_d = 1'b1;
        end
        // a flush on the completing edge must beat the row validation
        if (cache_flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            off_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            fseen_q <= 1'b0;
            ackd_q  <= 1'b0;
            early_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            row_q   <= row_d;
            base_q  <= base_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fseen_q <= fseen_d;
            ackd_q  <= ackd_d;
            early_q <= early_d;
        end
    end

endmodule

// File: tb/tb_fig_14_cache_fill_ctrl.sv
// Directed bench for the I-cache fill controller (both EARLY_RESTART_EN builds).
module tb_fig_14_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [12:0] pc = '0;
    logic        orange = 1'b0;
    logic [5:0]  cache_addr = '0;
    logic        cache_flush = 1'b0;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wcnt = 0;
    logic [12:0] rd_log[$];

    always #5 clk = ~clk;

    fig_14_cache_fill_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .orange      (orange),
        .cache_addr  (cache_addr),
        .cache_flush (cache_flush),
        .fetch_ack   (fetch_ack),
        .fetch_data  (fetch_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    // Memory contents: distinct per address, and row 0 differs from 0x0300.
    function automatic logic [7:0] mbyte(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b000};
    endfunction

    // Cycles from request sample to fetch_ack for a fill with offset off.
    function automatic int fill_cyc(input int off);
`ifdef EARLY_RESTART_EN
        return off + 2;
`else
        return 9;
`endif
    endfunction

    always @(negedge clk) begin
        if (mem_req && rst_n) begin
            if (wcnt >= lat) begin
                mem_ack = 1'b1;
                mem_data = mbyte(mem_addr);
                rd_log.push_back(mem_addr);
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [12:0] a,
                         input logic org, input logic [5:0] row,
                         input logic [7:0] exp_d, input int exp_cyc,
                         input int exp_n, input logic [12:0] exp_a0,
                         input int flush_at);
        int base;
        int cyc;
        int n;
        bit fl;
        base = rd_log.size();
        pc = a;
        orange = org;
        cache_addr = row;
        fetch_req = 1'b1;
        cyc = 0;
        fl = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
            cache_flush = 1'b0;
            if (flush_at >= 0 && !fl && rd_log.size() - base == flush_at) begin
                cache_flush = 1'b1;
                fl = 1;
            end
        end while (!fetch_ack && cyc < 100);
        chk({tag, "_ack"}, 32'(fetch_ack), 32'd1);
        chk({tag, "_data"}, 32'(fetch_data), 32'(exp_d));
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        fetch_req = 1'b0;
        @(posedge clk);
        #2;
        cache_flush = 1'b0;
        chk({tag, "_pulse"}, 32'(fetch_ack), 32'd0);
        n = 0;
        while (mem_req && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({tag, "_drain"}, 32'(mem_req), 32'd0);
        @(posedge clk);
        #2;
        chk({tag, "_nrd"}, 32'(rd_log.size() - base), 32'(exp_n));
        for (int i = 0; i < exp_n && base + i < rd_log.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), 32'(rd_log[base + i]),
                32'(exp_a0 + 13'(i)));
    endtask

    initial begin
        #12;
        chk("rst_ack", 32'(fetch_ack), 32'd0);
        chk("rst_data", 32'(fetch_data), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        fetch("t1", 13'h0105, 1'b0, 6'd0, 8'h0D, fill_cyc(5), 8, 13'h0100, -1);
        fetch("t2", 13'h0102, 1'b0, 6'd0, 8'h0A, 1, 0, 13'h0, -1);
        fetch("t3", 13'h0300, 1'b1, 6'd0, 8'h18, 2, 1, 13'h0300, -1);
        fetch("t3h", 13'h0100, 1'b0, 6'd0, 8'h08, 1, 0, 13'h0, -1);

        cache_flush = 1'b1;
        @(posedge clk);
        #2 cache_flush = 1'b0;
        fetch("t4", 13'h0102, 1'b0, 6'd0, 8'h0A, fill_cyc(2), 8, 13'h0100, -1);

        cache_flush = 1'b1;
        @(posedge clk);
        #2 cache_flush = 1'b0;
        fetch("t5", 13'h0105, 1'b0, 6'd0, 8'h0D, fill_cyc(5), 8, 13'h0100, 3);
        fetch("t5r", 13'h0105, 1'b0, 6'd0, 8'h0D, fill_cyc(5), 8, 13'h0100, -1);
        fetch("t5h", 13'h0107, 1'b0, 6'd0, 8'h0F, 1, 0, 13'h0, -1);

        fetch("t6a", 13'h010B, 1'b0, 6'd1, 8'h03, fill_cyc(3), 8, 13'h0108, -1);
        fetch("t6h", 13'h010B, 1'b0, 6'd1, 8'h03, 1, 0, 13'h0, -1);
        lat = 5;
        pc = 13'h0110;
        orange = 1'b0;
        cache_addr = 6'd2;
        fetch_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("t6_busy", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_ack", 32'(fetch_ack), 32'd0);
        chk("t6_data", 32'(fetch_data), 32'd0);
        fetch_req = 1'b0;
        lat = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        fetch("t6r1", 13'h010B, 1'b0, 6'd1, 8'h03, fill_cyc(3), 8, 13'h0108, -1);
        fetch("t6r0", 13'h0102, 1'b0, 6'd0, 8'h0A, fill_cyc(2), 8, 13'h0100, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
